// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
package fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] ALIGN_MASK       = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a word that returns while decode is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [INST_W-1:0] load_inst,
    output logic              valid,
    output logic [ADDR_W-1:0] buf_pc,
    output logic [INST_W-1:0] buf_inst
);

    // Clear wins over load so a redirect always empties the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            buf_pc   <= '0;
            buf_inst <= '0;
        end else if (clear) begin
            valid    <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            buf_pc   <= load_pc;
            buf_inst <= load_inst;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory request,
// tracks the fetch pc, and presents fetched words to decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst
);

    fetch_state_t      state_q, state_d;
    logic              req_q, req_d;
    logic              req_active_q, req_active_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ifv_q, ifv_d;
    logic [ADDR_W-1:0] ifpc_q, ifpc_d;
    logic [INST_W-1:0] ifinst_q, ifinst_d;
    logic              accept, pending;
    logic              skid_load, skid_clear, skid_valid;
    logic [ADDR_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_inst;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_pc   (pc_q),
        .load_inst (imem_rdata),
        .valid     (skid_valid),
        .buf_pc    (skid_pc),
        .buf_inst  (skid_inst)
    );

    // Next-state, pc and decode-slot updates; imem_req is registered so a
    // request already on the bus when stall rises lands in the skid slot.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_active_d = req_active_q;
        ifv_d        = ifv_q;
        ifpc_d       = ifpc_q;
        ifinst_d     = ifinst_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        req_d        = 1'b0;

        // An ack only counts against a request we are actually presenting,
        // so stray acks (e.g. after reset) are ignored.
        accept  = req_q & imem_ack;
        pending = req_q & ~imem_ack;

        if (pending)      req_active_d = 1'b1;
        else if (accept)  req_active_d = 1'b0;

        if (branch_flag && (state_q != ST_BOOT)) begin
            pc_d       = word_align(branch_target);
            ifv_d      = 1'b0;
            skid_clear = 1'b1;
            state_d    = pending ? ST_DRAIN : ST_FETCH;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (accept) begin
                        pc_d = pc_q + PC_STEP;
                        if (!stall || !ifv_q) begin
                            ifv_d    = 1'b1;
                            ifpc_d   = pc_q;
                            ifinst_d = imem_rdata;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end else if (!stall) begin
                        ifv_d = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (accept) state_d = ST_FETCH;
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifv_d      = skid_valid;
                        ifpc_d     = skid_pc;
                        ifinst_d   = skid_inst;
                        skid_clear = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end

        case (state_d)
            ST_DRAIN: req_d = 1'b1;
            ST_FETCH: req_d = req_active_d | ~stall | ~ifv_d;
            default:  req_d = 1'b0;
        endcase
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            req_q        <= 1'b0;
            req_active_q <= 1'b0;
            pc_q         <= RESET_PC;
            ifv_q        <= 1'b0;
            ifpc_q       <= '0;
            ifinst_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_active_q <= req_active_d;
            pc_q         <= pc_d;
            ifv_q        <= ifv_d;
            ifpc_q       <= ifpc_d;
            ifinst_q     <= ifinst_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign if_valid  = ifv_q;
    assign if_pc     = ifpc_q;
    assign if_inst   = ifinst_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: memory model, program-order scoreboard, directed
// corner cases and a randomized stall/ack/branch phase.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int consumed = 0;

    // Expected program-order fetch addresses still to be seen by decode.
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;
    logic [31:0] exp_e;

    // Memory content is a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Memory answers for the address captured when the request first appeared.
    logic        pend;
    logic [31:0] paddr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            paddr <= '0;
        end else if (imem_req && imem_ack) begin
            pend  <= 1'b0;
        end else if (imem_req && !pend) begin
            pend  <= 1'b1;
            paddr <= imem_addr;
        end
    end
    assign imem_rdata = pend ? mem_word(paddr) : mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endfunction

    function automatic void restart(input logic [31:0] start);
        exp_q.delete();
        next_pc = start & 32'hFFFF_FFFC;
        refill();
    endfunction

    // Decode takes the presented word at the coming edge when not stalled and
    // not being redirected; it must be the next word in program order.
    always @(negedge clk) begin
        if (!rst && if_valid && !stall && !branch_flag) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got if_pc %h with no expected entry", if_pc);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_if_pc", if_pc, exp_e);
                check("sb_if_inst", if_inst, mem_word(exp_e));
                consumed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        branch_flag = 1'b0;
        branch_target = '0;
        imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        restart(RST_PC);
        rst = 1'b0;
    endtask

    task automatic do_branch(input logic [31:0] t);
        branch_flag = 1'b1;
        branch_target = t;
        restart(t);
        tick();
        branch_flag = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got %0d tests", tests);
        $fatal(1, "timeout");
    end

    logic [31:0] a0, p1;
    int          idle;
    int          last_consumed;

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        branch_flag = 1'b0;
        branch_target = '0;
        imem_ack = 1'b0;
        next_pc = RST_PC;

        // Reset state, then streaming with ack tied high.
        do_reset();
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_pc", pc, RST_PC);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_inst", if_inst, 0);
        imem_ack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("stream_req", imem_req, 1);
            check("stream_addr", imem_addr, RST_PC + 32'(4 * i));
            if (i > 0) begin
                check("stream_valid", if_valid, 1);
                check("stream_if_pc", if_pc, RST_PC + 32'(4 * (i - 1)));
            end
            tick();
        end

        // Ack held off three cycles: request and address stay put.
        imem_ack = 1'b0;
        a0 = imem_addr;
        for (int i = 0; i < 3; i++) begin
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, a0);
            tick();
        end
        imem_ack = 1'b1;
        tick();
        check("wait_pc_step", imem_addr, a0 + 32'd4);
        check("wait_if_pc", if_pc, a0);
        check("wait_valid", if_valid, 1);

        // Stall with ack high: in-flight word goes to the skid slot.
        tick();
        tick();
        p1 = if_pc;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_if_pc", if_pc, p1);
            check("stall_valid", if_valid, 1);
            check("stall_req", imem_req, 0);
        end
        stall = 1'b0;
        tick();
        check("unstall_if_pc0", if_pc, p1 + 32'd4);
        tick();
        check("unstall_if_pc1", if_pc, p1 + 32'd8);

        // Branch while a request is outstanding: drain, discard, refetch.
        imem_ack = 1'b0;
        tick();
        do_branch(32'h0000_0103);
        check("drain_addr", imem_addr, 32'h0000_0100);
        check("drain_valid", if_valid, 0);
        check("drain_req", imem_req, 1);
        imem_ack = 1'b1;
        tick();
        check("drain_discard", if_valid, 0);
        tick();
        check("drain_new_valid", if_valid, 1);
        check("drain_new_pc", if_pc, 32'h0000_0100);
        check("drain_new_inst", if_inst, mem_word(32'h0000_0100));

        // Branch while stalled with a full skid slot.
        tick();
        stall = 1'b1;
        tick();
        check("hold_req", imem_req, 0);
        do_branch(32'h0000_2000);
        check("hold_br_valid", if_valid, 0);
        check("hold_br_addr", imem_addr, 32'h0000_2000);
        check("hold_br_req", imem_req, 1);
        stall = 1'b0;
        tick();
        check("hold_br_if_pc", if_pc, 32'h0000_2000);
        check("hold_br_if_valid", if_valid, 1);

        // Address wrap at the top of memory.
        do_branch(32'hFFFF_FFFC);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        tick();
        check("wrap_if_pc0", if_pc, 32'h0000_0000);

        // Branch during BOOT is ignored.
        do_reset();
        imem_ack = 1'b1;
        branch_flag = 1'b1;
        branch_target = 32'h0000_0500;
        tick();
        branch_flag = 1'b0;
        check("boot_br_addr", imem_addr, RST_PC);
        check("boot_br_req", imem_req, 1);
        tick();
        check("boot_br_if_pc", if_pc, RST_PC);

        // Reset asserted mid-request; a late ack must not be taken.
        tick();
        imem_ack = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_valid", if_valid, 0);
        check("mid_rst_pc", pc, RST_PC);
        check("mid_rst_if_pc", if_pc, 0);
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        restart(RST_PC);
        rst = 1'b0;
        check("late_ack_req", imem_req, 0);
        tick();
        check("late_ack_valid", if_valid, 0);
        check("restart_addr", imem_addr, RST_PC);
        check("restart_req", imem_req, 1);
        tick();
        check("restart_if_pc", if_pc, RST_PC);

        // Randomized stall/ack/branch traffic against the scoreboard.
        idle = 0;
        last_consumed = consumed;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 99) < 30);
            imem_ack = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 3) begin
                branch_flag = 1'b1;
                branch_target = $urandom;
                restart(branch_target);
            end else begin
                branch_flag = 1'b0;
            end
            tick();
            if (consumed == last_consumed) idle++;
            else idle = 0;
            last_consumed = consumed;
            if (idle > 200) begin
                tests++;
                fails++;
                $display("FAIL watchdog: got no progress for %0d cycles, required at most 200", idle);
                break;
            end
        end
        branch_flag = 1'b0;
        check("progress", 32'(consumed > 800), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  decode not accepting; hold if_* outputs.
REQ-005 branch_flag  input  1  redirect fetch this cycle.
REQ-006 branch_target  input  32  redirect address.
REQ-007 imem_ack  input  1  instruction memory returns data this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address (= pc).
REQ-011 pc  output  32  current fetch address register.
REQ-012 if_valid  output  1  if_inst/if_pc hold a valid instruction.
REQ-013 if_pc  output  32  address of if_inst.
REQ-014 if_inst  output  32  fetched instruction.

Function
REQ-015 States SHALL be BOOT, FETCH, DRAIN, HOLD; BOOT -> FETCH unconditionally after one cycle.
REQ-016 imem_req SHALL be 0 in BOOT and HOLD; in FETCH it SHALL be 1 when req_active=1 or stall=0 or if_valid=0; in DRAIN it SHALL be 1.
REQ-017 req_active SHALL set when imem_req=1 and imem_ack=0, and clear on imem_ack; while set, imem_req and imem_addr SHALL stay stable.
REQ-018 Zero-wait ack (imem_ack in same cycle as first imem_req) SHALL be supported; sustained throughput one instruction per cycle.
REQ-019 On ack in FETCH with branch_flag=0 and (stall=0 or if_valid=0): if_inst<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^32, wraps FFFF_FFFC->0).
REQ-020 On ack in FETCH with branch_flag=0, stall=1, if_valid=1: word and pc SHALL go to the skid entry, pc<=pc+4, state->HOLD.
REQ-021 In HOLD, when stall=0: skid entry SHALL move to if_*, skid cleared, state->FETCH.
REQ-022 stall=0 and no new ack in FETCH: if_valid<=0 (instruction consumed).
REQ-023 branch_flag=1 in FETCH/HOLD/DRAIN SHALL: pc<=branch_target with bits[1:0] forced 0; if_valid<=0; skid cleared; any data acked that cycle discarded.
REQ-024 Branch with request outstanding and no ack that cycle SHALL go to DRAIN; otherwise state->FETCH.
REQ-025 In DRAIN, returning ack data SHALL be discarded, then state->FETCH; a second branch in DRAIN updates pc only.
REQ-026 branch_flag SHALL take priority over stall; branch_flag in BOOT SHALL be ignored.
REQ-027 if_valid and imem_ack data SHALL never duplicate or drop an instruction absent a branch.

Reset
REQ-028 On rst=1 (asynchronous): state=BOOT, pc=RESET_PC, imem_req=0, req_active=0, if_valid=0, if_pc=0, if_inst=0, skid cleared.
REQ-029 Reset mid-request SHALL abandon the request; a late imem_ack after reset release SHALL be ignored until FETCH issues a new request.
REQ-030 First imem_req SHALL assert the cycle after BOOT, with imem_addr=RESET_PC.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the state encoding, RESET_PC default, and instruction/address width constants.
REQ-032 One sub-module fetch_skid_buf (one-entry pc+instruction buffer with valid) SHALL be used; remaining logic in fetch_ctrl.

Verification
REQ-033 Reset release, imem_ack tied 1, stall=0 -> imem_addr 0,4,8,12 on consecutive cycles; if_pc trails by one cycle; if_valid continuous.
REQ-034 imem_ack delayed 3 cycles -> imem_req and imem_addr held stable 3 cycles; one instruction delivered; pc advances by 4 once.
REQ-035 stall=1 for 4 cycles while ack=1 -> if_* frozen, one word captured in skid, no further imem_req; on release both words emitted in order, none lost.
REQ-036 branch_flag=1, branch_target=32'h0000_0103 during outstanding request -> DRAIN, late word discarded, next imem_addr=32'h0000_0100, if_valid=0 until new word.
REQ-037 branch_flag=1 with stall=1 and skid full -> skid and if_valid cleared; fetch resumes at target.
REQ-038 pc=32'hFFFF_FFFC acked -> pc wraps to 0; rst pulsed mid-request -> outputs reset immediately, restart at RESET_PC.
